io_out_capture: RTL and testbench
=================================

Name: io_out_capture

Overview:
- Sits directly downstream of accumulatorFull and watches its 16-bit Output bus.
- Records every change of the processor's output value into a small FIFO, so slower consumers never miss a value (display driver, serial logger, bench monitor).
- Drains through a valid/ready handshake.
- Keeps a sticky overflow flag and a saturating count of dropped samples.

Parameters:
WIDTH, 16, data width; matches the accumulator Output bus.
DEPTH, 8, FIFO entries; must be a power of two and at least 2.
ADDR_W, 3, log2(DEPTH); pointer width.
DROP_W, 8, width of the dropped-sample counter.

Ports:
CLK  input  1  system clock, rising-edge active.
reset  input  1  synchronous, active-high reset.
AccOut  input  WIDTH  Output bus of accumulatorFull.
capture_en  input  1  1 = change detection armed; 0 = no pushes (the reference register still tracks AccOut).
out_data  output  WIDTH  FIFO head (oldest captured value).
out_valid  output  1  FIFO non-empty; out_data is meaningful.
out_ready  input  1  consumer accepts the head this cycle.
count  output  ADDR_W+1  current occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
overflow  output  1  sticky: a sample was dropped since reset.
drop_cnt  output  DROP_W  number of dropped samples, saturating at all-ones.

Behaviour:
- One clock domain; all state updates on the CLK rising edge. Reset is synchronous and active-high: it is sampled only on CLK edges.
- Reset values:
  - prev = 0, rd_ptr = wr_ptr = 0, count = 0.
  - out_valid = 0, full = 0, overflow = 0, drop_cnt = 0.
  - out_data = 0 (masked to 0 while empty).
  - Memory contents are don't-care.
- Reset has priority over every other event. Reset mid-operation discards all queued entries, and the push or pop in that cycle does not happen.
- Change detect:
  - change = capture_en & (AccOut != prev).
  - prev <= AccOut every non-reset cycle, regardless of capture_en.
  - Consequence: a value present when capture_en rises is not captured until AccOut next changes.
- Push/pop definitions:
  - push_req = change.
  - pop = out_valid & out_ready.
  - push = push_req & (!full | pop).
  - When full and a pop occurs in the same cycle, the push succeeds and count is unchanged.
- Drop: push_req & full & !pop.
  - Sample discarded; overflow <= 1.
  - drop_cnt <= drop_cnt + 1, saturating at 2^DROP_W − 1.
  - FIFO contents unchanged.
- Pointer and count updates:
  - Push: mem[wr_ptr] <= AccOut; wr_ptr wraps modulo DEPTH.
  - Pop: rd_ptr wraps modulo DEPTH.
  - count <= count + push − pop.
- Show-ahead FIFO:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] when out_valid, else 0.
  - Both derive from registered state, with no combinational path from AccOut.
- Latency: AccOut changes before edge N. At edge N the value is written, and out_valid rises in the cycle after edge N (1 cycle) if the FIFO was empty.
- Empty and out_ready=1: no pop, nothing changes.
- Push while empty with out_ready=1: the entry becomes visible next cycle; it is not bypassed.
- Handshake rule: out_data and out_valid stay stable while out_valid=1 and out_ready=0. Only a pop advances the head.
- Ordering is strictly FIFO. Back-to-back changes on consecutive cycles each produce one entry.
- A value that changes and returns (A → B → A) yields 3 entries. Duplicates are suppressed only across consecutive cycles.

Test Plan:
- Reset: hold reset 3 cycles with AccOut=0xFF00 and capture_en=1 → after release count=0, out_valid=0, overflow=0, drop_cnt=0, out_data=0. First cycle after release captures 0xFF00 because prev=0, so out_valid=1 and out_data=0xFF00 one cycle later.
- Ordering/latency: out_ready=0; AccOut steps 0x0014 → 0x000A → 0x0800 → 0x001E, holding each 2 cycles → count=4. With out_ready=1, out_data reads 0x0014, 0x000A, 0x0800, 0x001E on 4 consecutive cycles, then out_valid=0.
- No duplicates / capture gating:
  - AccOut held at 0x0014 for 10 cycles → exactly one entry.
  - capture_en=0 while AccOut goes 0x0015 → 0x0016 → no entries.
  - Re-enable with AccOut still 0x0016 → none until the next change.
- Overflow: out_ready=0; push 10 distinct values (0x0001..0x000A) → count=8, full=1, overflow=1, drop_cnt=2. Drain yields 0x0001..0x0008 in order.
- Simultaneous full push/pop: FIFO full, out_ready=1, AccOut changes to 0x0014 → count stays 8, drop_cnt unchanged, 0x0014 is the last entry drained. Also check wrap-around by cycling 20 values through with continuous draining.
- Reset mid-operation: count=5 and reset asserted for 1 cycle while AccOut is changing → count=0, out_valid=0, overflow cleared; no stale entries appear afterwards.

Source files
------------

// File: rtl/io_out_capture.sv
// Captures every change of the accumulator output bus into a show-ahead FIFO
// drained by valid/ready, with a sticky overflow flag and a saturating drop counter.
module io_out_capture #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DROP_W = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [WIDTH-1:0]  AccOut,
  input  logic              capture_en,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [ADDR_W:0] DepthCount = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  prev_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic change, pop, push, drop;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == DepthCount);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  assign change = capture_en && (AccOut != prev_q);
  assign pop    = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push   = change && (!full || pop);
  assign drop   = change && full && !pop;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      prev_q  <= AccOut;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
      end
    end
  end

  // NOTE: storage is not reset; out_data is masked while empty, so stale
  // contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (!reset && push) mem_q[wr_ptr_q] <= AccOut;
  end

endmodule

// File: tb/tb_io_out_capture.sv
// Directed bench for io_out_capture: reset, ordering, gating, overflow,
// full push/pop, wrap-around, drop saturation and mid-operation reset.
module tb_io_out_capture;

  logic        clk;
  logic        reset;
  logic [15:0] acc_out;
  logic        capture_en;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  io_out_capture dut (
    .CLK        (clk),
    .reset      (reset),
    .AccOut     (acc_out),
    .capture_en (capture_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [15:0] order_vals [4];

  initial begin
    order_vals[0] = 16'h0014;
    order_vals[1] = 16'h000A;
    order_vals[2] = 16'h0800;
    order_vals[3] = 16'h001E;

    reset      = 1'b1;
    acc_out    = 16'hFF00;
    capture_en = 1'b1;
    out_ready  = 1'b0;
    tick(3);
    check("rst_count",    32'(count),     32'd0);
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    check("rst_drop",     32'(drop_cnt),  32'd0);
    check("rst_data",     32'(out_data),  32'h0);
    reset = 1'b0;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data",  32'(out_data),  32'hFF00);
    out_ready = 1'b1;
    tick();
    check("post_rst_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Ordering and one-cycle latency into an empty FIFO
    for (int i = 0; i < 4; i++) begin
      acc_out = order_vals[i];
      tick();
      if (i == 0) check("latency_valid", 32'(out_valid), 32'd1);
      tick();
    end
    check("order_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("order_data%0d", i), 32'(out_data), 32'(order_vals[i]));
      tick();
    end
    check("order_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Duplicate suppression and capture gating
    acc_out = 16'h0014;
    tick(10);
    check("nodup_count", 32'(count), 32'd1);
    capture_en = 1'b0;
    acc_out = 16'h0015;
    tick(2);
    acc_out = 16'h0016;
    tick(2);
    check("gated_count", 32'(count), 32'd1);
    capture_en = 1'b1;
    tick(3);
    check("rearm_count", 32'(count), 32'd1);
    acc_out = 16'h0017;
    tick();
    check("rearm_change_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    check("gate_data0", 32'(out_data), 32'h0014);
    tick();
    check("gate_data1", 32'(out_data), 32'h0017);
    tick();
    check("gate_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Overflow: 10 pushes into 8 entries
    for (int v = 1; v <= 10; v++) begin
      acc_out = 16'(v);
      tick();
    end
    check("ovf_count", 32'(count),    32'd8);
    check("ovf_full",  32'(full),     32'd1);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_drop",  32'(drop_cnt), 32'd2);

    // Full with simultaneous push and pop
    out_ready = 1'b1;
    acc_out   = 16'h0014;
    check("fullpp_head", 32'(out_data), 32'h0001);
    tick();
    check("fullpp_count", 32'(count),    32'd8);
    check("fullpp_full",  32'(full),     32'd1);
    check("fullpp_drop",  32'(drop_cnt), 32'd2);
    for (int v = 2; v <= 8; v++) begin
      check($sformatf("drain_%0d", v), 32'(out_data), 32'(v));
      tick();
    end
    check("drain_last", 32'(out_data), 32'h0014);
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Wrap-around with continuous draining
    for (int i = 0; i < 20; i++) begin
      acc_out = 16'h0100 + 16'(i);
      tick();
      check($sformatf("wrap_data%0d", i), 32'(out_data), 32'h100 + 32'(i));
      check($sformatf("wrap_count%0d", i), 32'(count), 32'd1);
    end
    tick();
    check("wrap_empty", 32'(out_valid), 32'd0);
    check("wrap_drop",  32'(drop_cnt),  32'd2);
    out_ready = 1'b0;

    // Drop counter saturation: 270 distinct values into 8 entries
    for (int i = 0; i < 270; i++) begin
      acc_out = 16'h0400 + 16'(i);
      tick();
    end
    check("sat_drop",  32'(drop_cnt), 32'hFF);
    check("sat_count", 32'(count),    32'd8);
    out_ready = 1'b1;
    check("sat_head", 32'(out_data), 32'h0400);
    tick(8);
    check("sat_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin
      acc_out = 16'h0200 + 16'(i);
      tick();
    end
    check("mid_count_before", 32'(count), 32'd5);
    reset   = 1'b1;
    acc_out = 16'h0300;
    tick();
    check("mid_count",    32'(count),     32'd0);
    check("mid_valid",    32'(out_valid), 32'd0);
    check("mid_overflow", 32'(overflow),  32'd0);
    check("mid_drop",     32'(drop_cnt),  32'd0);
    check("mid_data",     32'(out_data),  32'h0);
    reset = 1'b0;
    tick();
    check("mid_after_count", 32'(count),    32'd1);
    check("mid_after_data",  32'(out_data), 32'h0300);
    out_ready = 1'b1;
    tick();
    check("mid_after_empty", 32'(out_valid), 32'd0);
    tick(2);
    check("mid_no_stale", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
